// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one line-wide physical memory port between the
// I-cache miss path (read-only) and the D-cache miss/writeback path.
module pmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,

  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD, StGap} state_e;

  state_e                state_q;
  logic                  last_d_q;  // D held the most recent grant
  logic                  pmem_read_q;
  logic                  pmem_write_q;
  logic [ADDR_WIDTH-1:0] pmem_address_q;
  logic [LINE_WIDTH-1:0] pmem_wdata_q;

  logic d_req;
  logic pick_i;

  assign d_req  = d_read | d_write;
  // On a tie the side that did not win last time goes next.
  assign pick_i = i_read & (~d_req | last_d_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      last_d_q       <= 1'b1;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_i) begin
            state_q        <= StServeI;
            pmem_read_q    <= 1'b1;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= i_address;
          end else if (d_req) begin
            state_q        <= StServeD;
            pmem_read_q    <= d_read;
            pmem_write_q   <= d_write;
            pmem_address_q <= d_address;
            pmem_wdata_q   <= d_wdata;
          end
        end
        StServeI, StServeD: begin
          if (pmem_resp) begin
            state_q      <= StGap;
            last_d_q     <= (state_q == StServeD);
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  // Responses pass straight through, but only to the side holding the grant.
  assign i_resp  = (state_q == StServeI) & pmem_resp;
  assign d_resp  = (state_q == StServeD) & pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Random and directed stimulus for pmem_arbiter, checked every cycle against a
// transaction-level model of grants, spacing and memory contents.
module tb_pmem_arbiter;
  localparam int unsigned AW     = 16;
  localparam int unsigned LW     = 128;
  localparam int unsigned NLINES = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] i_address = '0, d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic          i_resp, d_resp, pmem_read, pmem_write, pmem_resp;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata, pmem_rdata;
  logic [AW-1:0] pmem_address;
  logic          mem_resp = 1'b0, spur = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign pmem_resp = mem_resp | spur;

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] line_init(input int k);
    if (k == 4) return {16{8'hA5}};
    return {k[31:0] * 32'h9E37_79B1, ~k[31:0], k[31:0] ^ 32'h5A5A_0F0F, 32'hC0DE_0000 + k[31:0]};
  endfunction

  // Memory model: random latency, one-cycle resp, then one respond cycle.
  logic [LW-1:0] mem [NLINES];
  initial begin
    int            cnt;
    logic [AW-1:0] ma;
    logic          mw;
    logic [LW-1:0] mwd;
    cnt = 0; ma = '0; mw = 1'b0; mwd = '0;
    pmem_rdata = '0;
    for (int k = 0; k < NLINES; k++) mem[k] = line_init(k);
    forever begin
      @(posedge clk); #1;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_resp = 1'b1;
          if (mw) mem[ma[AW-1:4]] = mwd;
          else    pmem_rdata = mem[ma[AW-1:4]];
        end
      end else if (mem_resp) begin
        mem_resp   = 1'b0;
        pmem_rdata = '0;
      end else if (pmem_read | pmem_write) begin
        ma  = pmem_address;
        mw  = pmem_write;
        mwd = pmem_wdata;
        cnt = $urandom_range(1, 4);
      end
    end
  end

  // Reference model and monitor (outputs sampled on the falling edge).
  logic [LW-1:0] ref_mem [NLINES];
  int            i_resp_cnt = 0, d_resp_cnt = 0;
  logic [LW-1:0] last_i_data = '0, last_d_data = '0;
  logic          grants [$];  // 0 = I, 1 = D
  initial begin
    int            t, idle_from;
    logic          prv_rst, strb_prev, presp_prev, ri_prev, dr_prev, dw_prev, last_d;
    logic [AW-1:0] ia_prev, da_prev;
    logic [LW-1:0] dwd_prev, exp_id, exp_dd;
    logic          strb, exp_strb, exp_i, exp_d;
    logic          cur_d, cur_rd, cur_wr;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] cur_wd;
    t = 0; idle_from = 0; prv_rst = 1'b1; strb_prev = 1'b0; presp_prev = 1'b0;
    ri_prev = 1'b0; dr_prev = 1'b0; dw_prev = 1'b0; last_d = 1'b1;
    ia_prev = '0; da_prev = '0; dwd_prev = '0;
    cur_d = 1'b0; cur_rd = 1'b0; cur_wr = 1'b0; cur_addr = '0; cur_wd = '0;
    for (int k = 0; k < NLINES; k++) ref_mem[k] = line_init(k);
    forever begin
      @(negedge clk);
      strb  = pmem_read | pmem_write;
      exp_i = 1'b0;
      exp_d = 1'b0;
      if (prv_rst) begin
        check_eq("reset_outputs", {pmem_read, pmem_write, pmem_address, pmem_wdata}, '0);
        last_d    = 1'b1;
        idle_from = t;
      end else if (strb_prev && presp_prev) begin
        check_eq("strobe_drop_after_resp", strb, 1'b0);
      end else if (strb_prev) begin
        check_eq("txn_hold", {pmem_read, pmem_write, pmem_address}, {cur_rd, cur_wr, cur_addr});
        if (cur_d) check_eq("txn_wdata", pmem_wdata, cur_wd);
        exp_i = pmem_resp & ~cur_d;
        exp_d = pmem_resp & cur_d;
      end else begin
        exp_strb = (t - 1 >= idle_from) && (ri_prev || dr_prev || dw_prev);
        check_eq("grant_start", strb, exp_strb);
        if (exp_strb) begin
          if (ri_prev && (dr_prev || dw_prev)) cur_d = ~last_d;
          else                                 cur_d = ~ri_prev;
          if (cur_d) begin
            cur_rd = dr_prev; cur_wr = dw_prev; cur_addr = da_prev; cur_wd = dwd_prev;
            check_eq("grant_d_fields", {pmem_read, pmem_write, pmem_address, pmem_wdata},
                     {cur_rd, cur_wr, cur_addr, cur_wd});
          end else begin
            cur_rd = 1'b1; cur_wr = 1'b0; cur_addr = ia_prev;
            check_eq("grant_i_fields", {pmem_read, pmem_write, pmem_address},
                     {cur_rd, cur_wr, cur_addr});
          end
          grants.push_back(cur_d);
        end
      end
      exp_id = exp_i ? ref_mem[cur_addr[AW-1:4]] : '0;
      exp_dd = exp_d ? (cur_wr ? pmem_rdata : ref_mem[cur_addr[AW-1:4]]) : '0;
      check_eq("resp_pulses", {i_resp, d_resp}, {exp_i, exp_d});
      check_eq("i_rdata", i_rdata, exp_id);
      check_eq("d_rdata", d_rdata, exp_dd);
      if (exp_i || exp_d) begin
        last_d    = exp_d;
        idle_from = t + 2;
        if (exp_d && cur_wr) ref_mem[cur_addr[AW-1:4]] = cur_wd;
      end
      if (i_resp) begin i_resp_cnt++; last_i_data = i_rdata; end
      if (d_resp) begin d_resp_cnt++; last_d_data = d_rdata; end
      prv_rst = reset; strb_prev = strb; presp_prev = pmem_resp;
      ri_prev = i_read; dr_prev = d_read; dw_prev = d_write;
      ia_prev = i_address; da_prev = d_address; dwd_prev = d_wdata;
      t++;
    end
  end

  // Requester behaviour: hold until the matching resp, then maybe re-request.
  int i_ack = 0, d_ack = 0;
  task automatic cyc(input int pi, input int pd);
    @(posedge clk); #1;
    if (i_resp_cnt != i_ack) begin
      i_ack = i_resp_cnt; i_read = 1'b0;
    end else if (!i_read && $urandom_range(99) < pi) begin
      i_read = 1'b1; i_address = AW'($urandom);
    end
    if (d_resp_cnt != d_ack) begin
      d_ack = d_resp_cnt; d_read = 1'b0; d_write = 1'b0;
    end else if (!(d_read || d_write) && $urandom_range(99) < pd) begin
      d_write = $urandom_range(1); d_read = ~d_write; d_address = AW'($urandom);
      d_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic run(input int n, input int pi, input int pd);
    for (int k = 0; k < n; k++) cyc(pi, pd);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0; i_ack = i_resp_cnt; d_ack = d_resp_cnt;
  endtask

  initial begin
    int base, ic, dc;
    logic seen;
    do_reset(3);

    // Single I read of line 4.
    ic = i_resp_cnt; dc = d_resp_cnt;
    i_read = 1'b1; i_address = 16'h0040;
    run(15, 0, 0);
    check_eq("single_i_count", i_resp_cnt - ic, 1);
    check_eq("single_i_no_d", d_resp_cnt - dc, 0);
    check_eq("single_i_data", last_i_data, {16{8'hA5}});

    // D write then read back of the same line.
    d_write = 1'b1; d_address = 16'h0100;
    d_wdata = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    run(15, 0, 0);
    d_read = 1'b1; d_address = 16'h0100;
    run(15, 0, 0);
    check_eq("d_readback", last_d_data, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321);

    // Simultaneous requests straight out of reset: I, D, I, D.
    do_reset(3);
    base = grants.size();
    i_read = 1'b1; i_address = AW'($urandom);
    d_read = 1'b1; d_address = AW'($urandom);
    for (int k = 0; k < 200 && grants.size() < base + 4; k++) cyc(100, 100);
    check_eq("alt_grant_count", grants.size() >= base + 4, 1'b1);
    if (grants.size() >= base + 4)
      for (int k = 0; k < 4; k++) check_eq("alt_grant_order", grants[base + k], k[0]);
    run(40, 0, 0);

    // D arrives while I is being served.
    i_read = 1'b1; i_address = 16'h0040;
    run(2, 0, 0);
    d_read = 1'b1; d_address = 16'h0100;
    run(30, 0, 0);

    // Spurious memory response while idle.
    spur = 1'b1;
    run(1, 0, 0);
    spur = 1'b0;
    run(2, 0, 0);
    i_read = 1'b1; i_address = 16'h0230;
    run(15, 0, 0);

    // Reset while a D transaction is in flight.
    d_read = 1'b1; d_address = AW'($urandom);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      run(1, 0, 0);
      seen = pmem_read;
    end
    check_eq("serve_d_reached", seen, 1'b1);
    do_reset(8);
    ic = i_resp_cnt;
    i_read = 1'b1; i_address = 16'h0040;
    run(15, 0, 0);
    check_eq("post_reset_i_count", i_resp_cnt - ic, 1);
    check_eq("post_reset_i_data", last_i_data, ref_mem[4]);

    // Random traffic.
    run(3000, 30, 30);
    run(40, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
